// File: rtl/d16_pkg.sv
// Shared types and constants for the d16 instruction-fetch sequencer.
// The state encoding and the counter command bundle are used by the FSM and by the top level.
package d16_pkg;

  localparam int D16_INSN_W  = 32;
  localparam int D16_ADR_W   = 16;
  localparam int D16_PC_STEP = 4;

  typedef enum logic [2:0] {
    RSTV  = 3'd0,
    FETCH = 3'd1,
    FLUSH = 3'd2,
    HOLD  = 3'd3,
    HALT  = 3'd4
  } d16_state_e;

  // Source of the value presented on the counter load input.
  typedef enum logic [1:0] {
    DIN_RSTV = 2'd0,
    DIN_BR   = 2'd1,
    DIN_PEND = 2'd2
  } d16_din_sel_e;

  typedef struct packed {
    logic         cpt_en;
    logic         cpt_load;
    d16_din_sel_e din_sel;
    logic         cap_ir;
    logic         cap_pend;
  } d16_fetch_cmd_t;

  function automatic logic [D16_ADR_W-1:0] d16_align(input logic [D16_ADR_W-1:0] adr);
    return adr & ~D16_ADR_W'(D16_PC_STEP - 1);
  endfunction

endpackage

// File: rtl/d16_fetch_fsm.sv
// Fetch sequencer FSM: state register, next-state decode and per-cycle counter/capture commands.
// Commands are combinational from state and inputs; sys_rst masks every command in the cycle it is high.
module d16_fetch_fsm
  import d16_pkg::*;
(
  input  logic           sys_clk,
  input  logic           sys_rst,
  input  logic           imem_ack,
  input  logic           br_valid,
  input  logic           halt_req,
  input  logic           ir_ready,
  output d16_state_e     state_o,
  output d16_fetch_cmd_t cmd_o
);

  d16_state_e state_q;
  d16_state_e state_d;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= RSTV;
    end else begin
      state_q <= state_d;
    end
  end

  // Halt is only honoured at an ack boundary or when decode takes the held word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RSTV: state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          if (br_valid) begin
            state_d = halt_req ? HALT : FETCH;
          end else begin
            state_d = HOLD;
          end
        end else if (br_valid) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (imem_ack) begin
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (br_valid) begin
          state_d = FETCH;
        end else if (ir_ready) begin
          state_d = halt_req ? HALT : FETCH;
        end
      end
      HALT: begin
        if (!br_valid && !halt_req) begin
          state_d = FETCH;
        end
      end
      default: state_d = RSTV;
    endcase
  end

  always_comb begin
    cmd_o = '0;
    case (state_q)
      RSTV: begin
        cmd_o.cpt_en   = 1'b1;
        cmd_o.cpt_load = 1'b1;
        cmd_o.din_sel  = DIN_RSTV;
      end
      FETCH: begin
        if (imem_ack) begin
          cmd_o.cpt_en   = 1'b1;
          cmd_o.cpt_load = br_valid;
          cmd_o.din_sel  = DIN_BR;
          cmd_o.cap_ir   = !br_valid;
        end else begin
          cmd_o.cap_pend = br_valid;
        end
      end
      FLUSH: begin
        if (imem_ack) begin
          cmd_o.cpt_en   = 1'b1;
          cmd_o.cpt_load = 1'b1;
          if (br_valid) begin
            cmd_o.din_sel = DIN_BR;
          end else begin
            cmd_o.din_sel = DIN_PEND;
          end
        end else begin
          cmd_o.cap_pend = br_valid;
        end
      end
      HOLD, HALT: begin
        if (br_valid) begin
          cmd_o.cpt_en   = 1'b1;
          cmd_o.cpt_load = 1'b1;
          cmd_o.din_sel  = DIN_BR;
        end
      end
      default: cmd_o = '0;
    endcase
    if (sys_rst) begin
      cmd_o = '0;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/d16_fetch_ctrl.sv
// d16 fetch control: steers the external +4 pointer counter and a req/ack imem port; best case one word per 2 cycles.
// Decode backpressure parks the word in ir_data with no request; D16_FETCH_ALIGN_TRAP_EN traps misaligned redirects.
module d16_fetch_ctrl
  import d16_pkg::*;
#(
  parameter logic [D16_ADR_W-1:0] RESET_VECTOR = 16'h0000
`ifdef D16_FETCH_ALIGN_TRAP_EN
  ,
  parameter logic [D16_ADR_W-1:0] TRAP_VECTOR  = 16'h0004
`endif
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [D16_ADR_W-1:0]  pc,
  output logic                  cpt_en,
  output logic                  cpt_load,
  output logic                  cpt_dir,
  output logic [D16_ADR_W-1:0]  cpt_din,
  output logic [D16_ADR_W-1:0]  imem_adr,
  output logic                  imem_req,
  input  logic                  imem_ack,
  input  logic [D16_INSN_W-1:0] imem_dat,
  output logic                  ir_valid,
  input  logic                  ir_ready,
  output logic [D16_INSN_W-1:0] ir_data,
  output logic [D16_ADR_W-1:0]  ir_pc,
  input  logic                  br_valid,
  input  logic [D16_ADR_W-1:0]  br_target,
  input  logic                  halt_req,
  output logic                  halted,
  output logic                  trap
);

  d16_state_e            state;
  d16_fetch_cmd_t        cmd;
  logic [D16_INSN_W-1:0] ir_data_q;
  logic [D16_ADR_W-1:0]  ir_pc_q;
  logic [D16_ADR_W-1:0]  pend_q;
  logic [D16_ADR_W-1:0]  raw_tgt;
  logic [D16_ADR_W-1:0]  eff_tgt;

  d16_fetch_fsm u_fsm (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .imem_ack (imem_ack),
    .br_valid (br_valid),
    .halt_req (halt_req),
    .ir_ready (ir_ready),
    .state_o  (state),
    .cmd_o    (cmd)
  );

  // pend holds the raw target so alignment and trap are resolved when the load is finally issued.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ir_data_q <= '0;
      ir_pc_q   <= '0;
      pend_q    <= '0;
    end else begin
      if (cmd.cap_ir) begin
        ir_data_q <= imem_dat;
        ir_pc_q   <= pc;
      end
      if (cmd.cap_pend) begin
        pend_q <= br_target;
      end
    end
  end

  assign raw_tgt = (cmd.din_sel == DIN_PEND) ? pend_q : br_target;

`ifdef D16_FETCH_ALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = |raw_tgt[1:0];
  assign eff_tgt    = misaligned ? TRAP_VECTOR : raw_tgt;
  assign trap       = cmd.cpt_load && (cmd.din_sel != DIN_RSTV) && misaligned;
`else
  assign eff_tgt    = d16_align(raw_tgt);
  assign trap       = 1'b0;
`endif

  assign cpt_en   = cmd.cpt_en;
  assign cpt_load = cmd.cpt_load;
  assign cpt_dir  = 1'b1;
  assign cpt_din  = (cmd.din_sel == DIN_RSTV) ? RESET_VECTOR : eff_tgt;

  assign imem_adr = pc;
  assign imem_req = (state == FETCH) || (state == FLUSH);

  assign ir_valid = (state == HOLD);
  assign halted   = (state == HALT);
  assign ir_data  = ir_data_q;
  assign ir_pc    = ir_pc_q;

endmodule

// File: tb/tb_d16_fetch_ctrl.sv
// Bench for d16_fetch_ctrl: directed scenarios then random traffic, checked each cycle against a fetch model.
// The bench also plays the pointer counter and instruction memory.
`timescale 1ns/1ps
module tb_d16_fetch_ctrl;

  localparam logic [15:0] RV = 16'h0100;
`ifdef D16_FETCH_ALIGN_TRAP_EN
  localparam bit          OPT    = 1'b1;
  localparam logic [15:0] LAST_D = 16'h0004;
`else
  localparam bit          OPT    = 1'b0;
  localparam logic [15:0] LAST_D = 16'h0300;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [15:0] pc;
  logic        cpt_en, cpt_load, cpt_dir;
  logic [15:0] cpt_din;
  logic [15:0] imem_adr;
  logic        imem_req, imem_ack;
  logic [31:0] imem_dat;
  logic        ir_valid, ir_ready;
  logic [31:0] ir_data;
  logic [15:0] ir_pc;
  logic        br_valid;
  logic [15:0] br_target;
  logic        halt_req, halted, trap;

  d16_fetch_ctrl #(.RESET_VECTOR(RV)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .pc(pc),
    .cpt_en(cpt_en), .cpt_load(cpt_load), .cpt_dir(cpt_dir), .cpt_din(cpt_din),
    .imem_adr(imem_adr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_dat(imem_dat),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_data(ir_data), .ir_pc(ir_pc),
    .br_valid(br_valid), .br_target(br_target), .halt_req(halt_req),
    .halted(halted), .trap(trap)
  );

  always #5 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: what fetch is doing, as plain flags, plus the word handed to decode.
  bit          m_boot, m_halt, m_buf, m_flush;
  logic [15:0] m_flush_tgt, m_pc_nx, m_irpc;
  logic [31:0] m_ird;
  logic [15:0] deliv[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] eff(input logic [15:0] t);
    if (OPT) return (t[1:0] != 2'b00) ? 16'h0004 : t;
    return {t[15:2], 2'b00};
  endfunction

  initial begin
    int wcnt;
    bit br2_done, br5_done, br6_done, br6_now, ld;
    logic e_req, e_en, e_load, e_trap;
    logic [15:0] e_din, ld_raw;
    logic [15:0] exp_d[11];

    exp_d = '{16'h0100, 16'h0104, 16'h0108, 16'h010C, 16'h0200, 16'h0204,
              16'h0208, 16'h020C, 16'hFFFC, 16'h0000, LAST_D};
    pc = 16'hBEEF; imem_ack = 0; imem_dat = '0; ir_ready = 0;
    br_valid = 0; br_target = '0; halt_req = 0;
    m_boot = 1; m_halt = 0; m_buf = 0; m_flush = 0;
    m_flush_tgt = '0; m_ird = '0; m_irpc = '0; m_pc_nx = pc;
    wcnt = 0; br2_done = 0; br5_done = 0; br6_done = 0;

    for (int t = 0; t < 3200; t++) begin
      @(posedge sys_clk);
      #1;
      cyc = t;
      pc  = m_pc_nx;
      sys_rst = (t < 3) || (t >= 60 && $urandom_range(0, 299) == 0);
      e_req = !m_boot && !m_halt && !m_buf;
      imem_dat  = $urandom;
      br_target = 16'($urandom);
      br_valid  = 1'b0;
      br6_now   = 1'b0;
      if (t < 45) begin
        imem_ack = e_req && (wcnt >= ((t >= 12 && t <= 15) ? 3 : 0));
        ir_ready = !(t >= 19 && t <= 22);
        halt_req = (t >= 24 && t <= 29);
        if (!br2_done && t >= 13 && e_req && !imem_ack) begin
          br_valid = 1; br_target = 16'h0200; br2_done = 1;
        end else if (!br5_done && t >= 33 && e_req && imem_ack && !m_flush) begin
          br_valid = 1; br_target = 16'hFFFC; br5_done = 1;
        end else if (br5_done && !br6_done && t >= 38 && e_req && imem_ack && !m_flush) begin
          br_valid = 1; br_target = 16'h0302; br6_done = 1; br6_now = 1;
        end
      end else begin
        imem_ack = e_req && ($urandom_range(0, 2) != 0);
        ir_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 19) == 0) halt_req = !halt_req;
        br_valid = ($urandom_range(0, 9) == 0);
      end
      if (sys_rst || !e_req || imem_ack) wcnt = 0;
      else wcnt++;

      // Expected counter commands for this cycle.
      e_en = 0; e_load = 0; e_trap = 0; e_din = 'x; ld = 0; ld_raw = br_target;
      if (!sys_rst) begin
        if (m_boot) begin
          e_en = 1; e_load = 1; e_din = RV;
        end else if (m_halt || m_buf) begin
          ld = br_valid;
        end else if (imem_ack) begin
          if (br_valid) ld = 1;
          else if (m_flush) begin ld = 1; ld_raw = m_flush_tgt; end
          else e_en = 1;
        end
        if (ld) begin
          e_en = 1; e_load = 1; e_din = eff(ld_raw);
          e_trap = OPT && (ld_raw[1:0] != 2'b00);
        end
      end

      @(negedge sys_clk);
      chk("imem_req", imem_req, e_req);
      if (e_req) chk("imem_adr", imem_adr, pc);
      chk("ir_valid", ir_valid, m_buf);
      if (m_buf) begin
        chk("ir_data", ir_data, m_ird);
        chk("ir_pc", ir_pc, m_irpc);
      end
      chk("halted", halted, m_halt);
      chk("trap", trap, e_trap);
      chk("cpt_dir", cpt_dir, 1);
      chk("cpt_en", cpt_en, e_en);
      if (e_en) chk("cpt_load", cpt_load, e_load);
      if (e_load) chk("cpt_din", cpt_din, e_din);
      if (t == 2) begin
        chk("rst_ir_data", ir_data, 0);
        chk("rst_ir_pc", ir_pc, 0);
        chk("rst_cpt_en", cpt_en, 0);
        chk("rst_req", imem_req, 0);
      end
      if (t == 3) chk("boot_din", cpt_din, 16'h0100);
      if (t == 21) begin
        chk("stall_valid", ir_valid, 1);
        chk("stall_pc", ir_pc, 16'h0204);
        chk("stall_req", imem_req, 0);
      end
      if (t == 28) chk("halt_level", halted, 1);
      if (br6_now) begin
        chk("br6_trap", trap, OPT ? 1 : 0);
        chk("br6_din", cpt_din, LAST_D);
      end

      if (t < 45 && !sys_rst && m_buf && ir_ready && !br_valid) deliv.push_back(m_irpc);

      // Advance the model to the next cycle.
      m_pc_nx = e_en ? (e_load ? e_din : pc + 16'd4) : pc;
      if (sys_rst) begin
        m_boot = 1; m_halt = 0; m_buf = 0; m_flush = 0; m_ird = '0; m_irpc = '0;
      end else if (m_boot) begin
        m_boot = 0;
      end else if (m_halt) begin
        if (!br_valid && !halt_req) m_halt = 0;
      end else if (m_buf) begin
        if (br_valid) m_buf = 0;
        else if (ir_ready) begin m_buf = 0; m_halt = halt_req; end
      end else if (imem_ack) begin
        if (m_flush) m_flush = 0;
        else if (br_valid) m_halt = halt_req;
        else begin m_buf = 1; m_ird = imem_dat; m_irpc = pc; end
      end else if (br_valid) begin
        m_flush = 1; m_flush_tgt = br_target;
      end
    end

    chk("deliv_count_ok", deliv.size() >= 11, 1);
    for (int i = 0; i < 11; i++) begin
      if (i < deliv.size()) chk($sformatf("deliv%0d", i), deliv[i], exp_d[i]);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/d16_fetch_ctrl.md
Name: d16_fetch_ctrl

Overview:
Instruction-fetch sequencer for the d16 core; owns the control inputs of the 16-bit instruction-pointer counter (en/load/dir/din, +4 step).
Issues req/ack reads to instruction memory at the current pointer and hands fetched words to decode with a valid/ready handshake.
Redirects the pointer on branches and handles halt.
Never writes the pointer while a memory request is outstanding.

Parameters:
RESET_VECTOR, 16'h0000, pointer value loaded after reset
TRAP_VECTOR, 16'h0004, pointer loaded on misaligned branch (optional feature only)

Ports:
sys_clk  in  1  clock
sys_rst  in  1  reset, synchronous, active-high
pc  in  16  current counter value (dout of the pointer counter)
cpt_en  out  1  counter enable
cpt_load  out  1  counter load select
cpt_dir  out  1  counter direction, constant 1 (increment)
cpt_din  out  16  counter load value
imem_adr  out  16  fetch address, combinationally equal to pc
imem_req  out  1  fetch request, held until ack
imem_ack  in  1  fetch complete, imem_dat valid this cycle
imem_dat  in  32  fetched instruction
ir_valid  out  1  instruction available to decode
ir_ready  in  1  decode accepts instruction
ir_data  out  32  registered instruction
ir_pc  out  16  address of ir_data
br_valid  in  1  branch/jump redirect request, single-cycle pulse
br_target  in  16  redirect address
halt_req  in  1  level: stop fetching
halted  out  1  fetch stopped
trap  out  1  misaligned-branch pulse (optional feature only, else tied 0)

Behaviour:
- Reset (sync, active-high, dominates everything): state=RSTV; cpt_en=cpt_load=imem_req=ir_valid=halted=trap=0; ir_data=0; ir_pc=0; pend=0. An outstanding request is abandoned, with req dropping the next cycle.
- cpt_* outputs are combinational from state/inputs. Counter update is visible on pc one cycle after cpt_en.
- RSTV: cpt_en=1, cpt_load=1, cpt_din=RESET_VECTOR for one cycle -> FETCH.
- FETCH: imem_req=1.
  - ack & !br_valid: latch ir_data=imem_dat, ir_pc=pc; ir_valid<=1; pulse cpt_en=1, load=0 (pc+4, wraps 16'hFFFC->16'h0000) -> HOLD.
  - ack & br_valid: discard data; load br_target -> FETCH (or HALT if halt_req).
  - !ack & br_valid: pend<=br_target -> FLUSH.
  - !ack & halt_req: stay; halt only takes effect at an ack boundary.
- FLUSH: imem_req=1 at unchanged address.
  - On ack: discard data, load pend -> FETCH.
  - A later br_valid while in FLUSH overwrites pend (last wins).
- HOLD: ir_valid=1; no request.
  - ir_ready & !br_valid: ir_valid<=0 -> FETCH, or HALT if halt_req.
  - br_valid (with or without ready): ir_valid<=0, instruction dropped, load br_target -> FETCH.
- HALT: halted=1, no request, ir_valid=0.
  - halt_req=0 -> FETCH.
  - br_valid in HALT: load target, stay in HALT.
- Throughput: one instruction per 2 cycles minimum with 1-cycle ack (FETCH+HOLD). Branch penalty is 1 cycle after the redirect.
- Without the option, br_target[1:0] is forced to 2'b00 before loading.

Optional Feature:
D16_FETCH_ALIGN_TRAP_EN
- Defined: a redirect with br_target[1:0]!=0 loads TRAP_VECTOR instead and pulses trap for one cycle, in the cycle the load is issued.
- Undefined: no trap logic; the low bits are masked and trap is tied 0.

Decomposition:
- Shared package d16_pkg holds: state encoding (RSTV, FETCH, FLUSH, HOLD, HALT; 3 bits), the D16_INSN_W=32 and D16_ADR_W=16 constants, and the D16_PC_STEP=4 constant.
- One natural sub-module, d16_fetch_fsm: state register plus next-state/command decode. The top level holds the ir_data/ir_pc/pend registers and the alignment/trap logic.

Test Plan:
1. Reset release with RESET_VECTOR=16'h0100, 1-cycle ack -> load pulse with cpt_din=0x0100, then fetches at 0x0100, 0x0104, 0x0108; ir_pc matches each; ir_ready held 1.
2. ack delayed 3 cycles, br_valid target 0x0200 in the second wait cycle -> req held at the old address until ack, data discarded, next fetch at 0x0200, no ir_valid for the old word.
3. HOLD with ir_ready=0 for 4 cycles -> ir_valid and ir_data stable, no imem_req; ir_ready then yields next fetch at +4.
4. halt_req during FETCH -> completes ack, delivers the word, enters HALT, halted=1; release -> resumes at the next sequential address.
5. pc=0xFFFC sequential fetch -> next pc 0x0000, fetch continues.
6. br_target=0x0302: with the option, trap pulse and fetch at TRAP_VECTOR 0x0004; without it, fetch at 0x0300.
